// File: rtl/seq_det_scheduler.sv
// One PLEN-bit pattern detector shared round-robin across NCH serial channels.
// Each channel keeps its own history and count context, which is restored whenever that channel is granted.
module seq_det_ctx #(
  parameter int              PLEN    = 3,
  parameter logic [PLEN-1:0] PATTERN = 3'b101,
  parameter bit              OVERLAP = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic bit_in,
  output logic hit
);
  localparam int CW = $clog2(PLEN + 1);

  logic [PLEN-1:0] hist, nh;
  logic [CW-1:0]   cnt;
  logic            full;

  assign nh   = {hist[PLEN-2:0], bit_in};
  assign full = ({1'b0, cnt} + (CW+1)'(1)) >= (CW+1)'(PLEN);
  assign hit  = load && full && (nh == PATTERN);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      cnt  <= '0;
    end else if (load) begin
      if (hit) begin
        hist <= OVERLAP ? nh : '0;
        cnt  <= OVERLAP ? CW'(PLEN) : '0;
      end else begin
        hist <= nh;
        cnt  <= (cnt == CW'(PLEN)) ? cnt : cnt + CW'(1);
      end
    end
  end
endmodule

module seq_det_scheduler #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 3,
  parameter logic [PLEN-1:0] PATTERN = 3'b101,
  parameter bit              OVERLAP = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH-1:0]         in_bit,
  output logic [NCH-1:0]         in_ready,
  input  logic [NCH-1:0]         ch_clear,
  output logic                   match_valid,
  output logic [$clog2(NCH)-1:0] match_ch,
  output logic [15:0]            match_total
);
  localparam int IW = $clog2(NCH);

  logic [NCH-1:0]   elig, rot, hit;
  logic [2*NCH-1:0] dbl;
  logic [IW-1:0]    rr_ptr, off, gnt;
  logic [IW:0]      sum;
  logic             found, go, match;

  // A cleared channel is excluded from arbitration, so its pending bit stays at the source.
  assign elig = in_valid & ~ch_clear;
  assign dbl  = {elig, elig} >> rr_ptr;
  assign rot  = dbl[NCH-1:0];

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = IW'(k);
        found = 1'b1;
      end
    end
  end

  assign sum      = {1'b0, rr_ptr} + {1'b0, off};
  assign gnt      = (sum >= (IW+1)'(NCH)) ? IW'(sum - (IW+1)'(NCH)) : IW'(sum);
  assign go       = found & enable & ~reset;
  assign in_ready = go ? (NCH'(1) << gnt) : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    seq_det_ctx #(
      .PLEN    (PLEN),
      .PATTERN (PATTERN),
      .OVERLAP (OVERLAP)
    ) u_ctx (
      .clk    (clk),
      .reset  (reset),
      .clear  (ch_clear[i]),
      .load   (in_ready[i]),
      .bit_in (in_bit[i]),
      .hit    (hit[i])
    );
  end

  assign match = |hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      match_total <= '0;
    end else begin
      match_valid <= match;
      if (go)
        rr_ptr <= (gnt == IW'(NCH - 1)) ? '0 : gnt + IW'(1);
      if (match) begin
        match_ch <= gnt;
        if (match_total != 16'hFFFF)
          match_total <= match_total + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench: default, overlapping and a 2-channel "11" instance for saturation.
module tb_seq_det_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_reset, d_enable;
  logic [3:0]  d_valid, d_bit, d_clear;
  logic [3:0]  a_ready, o_ready;
  logic        a_mv, o_mv;
  logic [1:0]  a_ch, o_ch;
  logic [15:0] a_tot, o_tot;

  logic        s_reset, s_enable;
  logic [1:0]  s_valid, s_bit, s_clear, s_ready;
  logic        s_mv, s_ch;
  logic [15:0] s_tot;

  logic [4:0]  t1_bits = 5'b10101;
  int n_vec = 0, n_err = 0;

  seq_det_scheduler u_def (
    .clk(clk), .reset(d_reset), .enable(d_enable), .in_valid(d_valid), .in_bit(d_bit),
    .in_ready(a_ready), .ch_clear(d_clear), .match_valid(a_mv), .match_ch(a_ch), .match_total(a_tot));

  seq_det_scheduler #(.OVERLAP(1'b1)) u_ovl (
    .clk(clk), .reset(d_reset), .enable(d_enable), .in_valid(d_valid), .in_bit(d_bit),
    .in_ready(o_ready), .ch_clear(d_clear), .match_valid(o_mv), .match_ch(o_ch), .match_total(o_tot));

  seq_det_scheduler #(.NCH(2), .PLEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) u_sat (
    .clk(clk), .reset(s_reset), .enable(s_enable), .in_valid(s_valid), .in_bit(s_bit),
    .in_ready(s_ready), .ch_clear(s_clear), .match_valid(s_mv), .match_ch(s_ch), .match_total(s_tot));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_rst();
    d_reset = 1'b1; d_valid = '0; d_bit = '0; d_clear = '0;
    step();
    d_reset = 1'b0;
  endtask

  // One cycle on the default instance: drive, check grant, clock, check the match report.
  task automatic cyc(input string tag, input logic en, input logic [3:0] v, input logic [3:0] b,
                     input logic [3:0] cl, input logic [3:0] rdy, input logic mv, input logic [1:0] ch);
    d_enable = en; d_valid = v; d_bit = b; d_clear = cl;
    #1;
    chk({tag, "_rdy"}, a_ready, rdy);
    step();
    chk({tag, "_mv"}, a_mv, mv);
    if (mv) chk({tag, "_ch"}, a_ch, ch);
  endtask

  initial begin
    d_reset = 1'b1; d_enable = 1'b1; d_valid = 4'hF; d_bit = '0; d_clear = '0;
    s_reset = 1'b1; s_enable = 1'b1; s_valid = 2'b11; s_bit = '0; s_clear = '0;
    #1;
    chk("rst_rdy", a_ready, 0);
    chk("rst_srdy", s_ready, 0);
    step(); step();
    chk("rst_mv", a_mv, 0);
    chk("rst_ch", a_ch, 0);
    chk("rst_tot", a_tot, 0);
    chk("rst_stot", s_tot, 0);
    d_valid = '0; d_reset = 1'b0;
    s_valid = '0; s_reset = 1'b0;

    // Stream 1,0,1,0,1 on ch0 into both the default and the overlapping instance.
    for (int k = 0; k < 5; k++) begin
      d_valid = 4'b0001; d_bit = {3'b000, t1_bits[4-k]};
      #1;
      chk("t1_rdy", a_ready, 4'b0001);
      chk("t1o_rdy", o_ready, 4'b0001);
      step();
      chk("t1_mv", a_mv, (k == 2));
      chk("t1o_mv", o_mv, (k == 2 || k == 4));
    end
    d_valid = '0;
    step();
    chk("t1_idle", a_mv, 0);
    chk("t1_tot", a_tot, 1);
    chk("t1_ch", a_ch, 0);
    chk("t1o_tot", o_tot, 2);
    chk("t1o_ch", o_ch, 0);

    // All four channels request every cycle, each fed 1,0,1.
    d_rst();
    for (int c = 0; c < 13; c++)
      cyc("t3", 1'b1, (c < 12) ? 4'hF : 4'h0, ((c / 4) == 1) ? 4'h0 : 4'hF, 4'h0,
          (c < 12) ? 4'(1 << (c % 4)) : 4'h0, (c >= 8 && c < 12), 2'(c - 8));
    chk("t3_tot", a_tot, 4);

    // Interleaving isolation plus an enable drop in the middle of ch0's pattern.
    d_rst();
    cyc("t4a", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t4b", 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0);
    cyc("t4c", 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t4d", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
    cyc("t4e", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0);
    cyc("t4f", 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
    cyc("t4g", 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1);
    chk("t4_tot", a_tot, 2);

    // ch_clear on ch0 blocks its grant; ch1 is still granted and keeps its history.
    d_rst();
    cyc("t5a", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t5b", 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t5c", 1'b1, 4'b0011, 4'b0011, 4'b0001, 4'b0010, 1'b0, 2'd0);
    cyc("t5d", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t5e", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t5f", 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("t5g", 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
    cyc("t5h", 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1);
    chk("t5_tot", a_tot, 1);
    d_valid = '0;

    // Saturation: a "11" overlapping detector matches on every bit after the first.
    s_valid = 2'b01; s_bit = 2'b01;
    #1;
    chk("sat_rdy", s_ready, 2'b01);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_fffe", s_tot, 16'hFFFE);
    step();
    chk("sat_ffff", s_tot, 16'hFFFF);
    step(); step();
    chk("sat_hold", s_tot, 16'hFFFF);
    chk("sat_mv", s_mv, 1);

    // Mid-pattern reset discards history and returns the pointer to ch0.
    s_reset = 1'b1;
    #1;
    chk("srst_rdy", s_ready, 0);
    step();
    chk("srst_mv", s_mv, 0);
    chk("srst_tot", s_tot, 0);
    chk("srst_ch", s_ch, 0);
    s_reset = 1'b0; s_valid = 2'b11; s_bit = 2'b11;
    #1;
    chk("srst_ptr", s_ready, 2'b01);
    step();
    chk("srst_first", s_mv, 0);
    s_valid = 2'b01;
    step();
    chk("srst_second", s_mv, 1);
    chk("srst_tot1", s_tot, 1);
    s_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
